mem_port_arbiter: RTL and testbench

- Shares one single-ported external memory bus between two requesters:
  - the instruction-fetch stage (read-only);
  - the memory-access stage (read/write).
- Produces the fetch_done and mem_done levels that the pipeline controller consumes for its stall and flush decisions.
- Arbitration is fixed-priority, data first, with an anti-starvation limit for fetch.
- Supports discarding a cancelled fetch that is already in flight, and a bus watchdog.

---
 rtl/mem_bus_pkg.sv | 32 +++
 rtl/bus_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding, bus owner and counter widths.
package mem_bus_pkg;

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned WD_W     = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INST_BUSY  = 2'd1,
        DATA_BUSY  = 2'd2,
        INST_DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    // A draining fetch has been abandoned, so its response belongs to nobody.
    function automatic owner_e state_owner(state_e s);
        owner_e o;
        o = OWN_NONE;
        case (s)
            INST_BUSY: o = OWN_INST;
            DATA_BUSY: o = OWN_DATA;
            default:   o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts stalled bus cycles and raises a one-cycle expire pulse when the limit is reached.
module bus_watchdog
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Expires during the TIMEOUT_CYCLES-th stalled cycle so mem_req drops on that edge.
    assign expire_c = en && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (clr || expire_c) begin
            wd_cnt <= '0;
        end else if (en) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store, data-first with
// an anti-starvation limit for fetch, in-flight fetch cancel and a bus watchdog.
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inst_req,
    input  logic [ADDR_WIDTH-1:0]     inst_addr,
    input  logic                      inst_cancel,
    output logic [DATA_WIDTH-1:0]     inst_rdata,
    output logic                      inst_valid,
    output logic                      inst_done,
    input  logic                      data_req,
    input  logic                      data_we,
    input  logic [DATA_WIDTH/8-1:0]   data_be,
    input  logic [ADDR_WIDTH-1:0]     data_addr,
    input  logic [DATA_WIDTH-1:0]     data_wdata,
    output logic [DATA_WIDTH-1:0]     data_rdata,
    output logic                      data_valid,
    output logic                      data_done,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      bus_err
);

    localparam int unsigned         BE_W       = DATA_WIDTH / 8;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  mem_req_d, mem_we_d;
    logic [BE_W-1:0]       mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic                  inst_valid_d, data_valid_d, bus_err_d;
    logic [DATA_WIDTH-1:0] inst_rdata_d, data_rdata_d;
    owner_e                owner_c;

    logic inst_elig, data_elig, grant_data, grant_inst;
    logic wd_en, wd_clr, wd_expire_c;

    // A requester whose response is being delivered this cycle must not be re-granted.
    assign inst_elig  = inst_req && !inst_valid;
    assign data_elig  = data_req && !data_valid;
    assign grant_data = data_elig && ((starve_q < STARVE_MAX) || !inst_elig);
    assign grant_inst = !grant_data && inst_elig && !inst_cancel;

    assign inst_done = !inst_req || inst_valid;
    assign data_done = !data_req || data_valid;

    assign wd_en  = mem_req && !mem_ack;
    assign wd_clr = (state_q == IDLE) || mem_ack;

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (wd_en),
        .clr      (wd_clr),
        .expire_c (wd_expire_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_be_d     = mem_be;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        inst_valid_d = 1'b0;
        inst_rdata_d = inst_rdata;
        data_valid_d = 1'b0;
        data_rdata_d = data_rdata;
        bus_err_d    = 1'b0;

        owner_c = state_owner(state_q);
        if ((state_q == INST_BUSY) && inst_cancel) begin
            owner_c = OWN_NONE;
        end

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = DATA_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we;
                    mem_be_d    = data_be;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    if (inst_elig && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (grant_inst) begin
                    state_d     = INST_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = inst_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            default: begin
                if (mem_req && mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (owner_c == OWN_INST) begin
                        inst_valid_d = 1'b1;
                        inst_rdata_d = mem_rdata;
                    end
                    if (owner_c == OWN_DATA) begin
                        data_valid_d = 1'b1;
                        data_rdata_d = mem_rdata;
                    end
                end else if (wd_expire_c) begin
                    // Complete the stalled owner with zero data so the pipeline keeps moving.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (owner_c == OWN_INST) begin
                        inst_valid_d = 1'b1;
                        inst_rdata_d = '0;
                    end
                    if (owner_c == OWN_DATA) begin
                        data_valid_d = 1'b1;
                        data_rdata_d = '0;
                    end
                end else if ((state_q == INST_BUSY) && (owner_c == OWN_NONE)) begin
                    state_d = INST_DRAIN;
                end
            end
        endcase

        if (!inst_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_valid <= 1'b0;
            inst_rdata <= '0;
            data_valid <= 1'b0;
            data_rdata <= '0;
            bus_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_be     <= mem_be_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            inst_valid <= inst_valid_d;
            inst_rdata <= inst_rdata_d;
            data_valid <= data_valid_d;
            data_rdata <= data_rdata_d;
            bus_err    <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        inst_req, inst_cancel;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_valid, inst_done;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_valid, data_done;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int checks;
    int failures;

    // Reference model: one outstanding transaction, who owns it, and what is expected on the pins.
    bit          m_busy, m_drop;
    int          m_owner;     // 0 none, 1 fetch, 2 load/store
    int          m_wait, m_starve;
    logic        m_req, m_we, m_iv, m_dv, m_err;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_ir, m_dr;

    mem_port_arbiter #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .STARVE_LIMIT   (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_cancel (inst_cancel),
        .inst_rdata  (inst_rdata),
        .inst_valid  (inst_valid),
        .inst_done   (inst_done),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_be     (data_be),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_valid  (data_valid),
        .data_done   (data_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_drop = 0; m_owner = 0; m_wait = 0; m_starve = 0;
        m_req = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
        m_iv = 0; m_ir = '0; m_dv = 0; m_dr = '0; m_err = 0;
    endtask

    task automatic model_deliver(input logic [31:0] v);
        if (m_owner == 2) begin
            m_dv = 1; m_dr = v;
        end else if (!m_drop) begin
            m_iv = 1; m_ir = v;
        end
        m_busy = 0;
        m_owner = 0;
    endtask

    task automatic model_clock();
        bit ie, de;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ie = inst_req && !m_iv;
        de = data_req && !m_dv;
        m_iv = 0; m_dv = 0; m_err = 0;
        if (!m_busy) begin
            if (de && (m_starve < SL || !ie)) begin
                m_busy = 1; m_owner = 2; m_drop = 0; m_wait = 0;
                m_we = data_we; m_be = data_be; m_addr = data_addr; m_wdata = data_wdata;
                if (ie && m_starve < SL) m_starve = m_starve + 1;
            end else if (ie && !inst_cancel) begin
                m_busy = 1; m_owner = 1; m_drop = 0; m_wait = 0;
                m_we = 0; m_be = 4'hF; m_addr = inst_addr; m_wdata = '0;
                m_starve = 0;
            end
        end else begin
            if (m_owner == 1 && inst_cancel) m_drop = 1;
            if (mem_ack) begin
                model_deliver(mem_rdata);
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == TO) begin
                    m_err = 1;
                    model_deliver('0);
                end
            end
        end
        if (!inst_req) m_starve = 0;
        m_req = m_busy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        inst_req = 0; inst_addr = '0; inst_cancel = 0;
        data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if ({mem_req, mem_we, mem_be} !== 6'h0) begin failures++; $display("FAIL reset_ctl got=%h exp=0", {mem_req, mem_we, mem_be}); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("FAIL reset_bus got=%h exp=0", {mem_addr, mem_wdata}); end
        checks++; if ({inst_valid, data_valid, bus_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {inst_valid, data_valid, bus_err}); end
        checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {inst_rdata, data_rdata}); end
        checks++; if ({inst_done, data_done} !== 2'b11) begin failures++; $display("FAIL reset_done got=%b exp=11", {inst_done, data_done}); end
    endtask

    task automatic test_single_fetch();
        do_reset();
        inst_req = 1; inst_addr = 32'h40;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_c0_req got=%b exp=0", mem_req); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            mem_ack = (c == 3);
            mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            checks++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h40}) begin
                failures++; $display("FAIL fetch_bus c%0d got=%h exp=%h", c, {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h40});
            end
        end
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL fetch_valid got=%b exp=1", inst_valid); end
        checks++; if (inst_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", inst_rdata); end
        checks++; if (inst_done !== 1'b1) begin failures++; $display("FAIL fetch_done got=%b exp=1", inst_done); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_c4_req got=%b exp=0", mem_req); end
        next_cycle();
        inst_req = 0;
        @(negedge clk);
        checks++; if ({mem_req, inst_valid} !== 2'b00) begin failures++; $display("FAIL fetch_reissue got=%b exp=00", {mem_req, inst_valid}); end
    endtask

    task automatic test_simultaneous();
        int dv_c, iv_c, age;
        bit seen;
        logic        first_we;
        logic [31:0] first_addr;
        do_reset();
        dv_c = -1; iv_c = -1; age = 0; seen = 0; first_we = 0; first_addr = '0;
        inst_req = 1; inst_addr = 32'h44;
        data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h100; data_wdata = 32'hA5A5;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                next_cycle();
                if (dv_c >= 0) data_req = 0;
                if (iv_c >= 0) inst_req = 0;
                age = mem_req ? age + 1 : 0;
                mem_ack = (age == 2);
                mem_rdata = 32'h1000 + 32'(c);
            end
            @(negedge clk);
            if (mem_req && !seen) begin seen = 1; first_we = mem_we; first_addr = mem_addr; end
            if (data_valid && dv_c < 0) dv_c = c;
            if (inst_valid && iv_c < 0) iv_c = c;
        end
        checks++; if ({first_we, first_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL simul_first got=%h exp=%h", {first_we, first_addr}, {1'b1, 32'h100}); end
        checks++; if (dv_c != 3) begin failures++; $display("FAIL simul_dvalid_cycle got=%0d exp=3", dv_c); end
        checks++; if (iv_c != 6) begin failures++; $display("FAIL simul_ivalid_cycle got=%0d exp=6", iv_c); end
    endtask

    task automatic test_starvation();
        logic [31:0] gq[$];
        int  n_data, n_inst;
        logic prev;
        do_reset();
        n_data = 0; n_inst = 0; prev = 0;
        inst_req = 1; inst_addr = 32'h40; inst_cancel = 1;
        data_req = 1; data_we = 0; data_be = 4'hF; data_addr = 32'h100;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin next_cycle(); mem_ack = mem_req; end
            @(negedge clk);
            if (mem_req && !prev) begin
                if (mem_addr == 32'h100) n_data++; else n_inst++;
            end
            prev = mem_req;
        end
        checks++; if (n_data != SL) begin failures++; $display("FAIL starve_data_grants got=%0d exp=%0d", n_data, SL); end
        checks++; if (n_inst != 0) begin failures++; $display("FAIL starve_inst_grants got=%0d exp=0", n_inst); end
        inst_cancel = 0;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            mem_ack = mem_req;
            @(negedge clk);
            if (mem_req && !prev) gq.push_back(mem_addr);
            prev = mem_req;
        end
        checks++;
        if (gq.size() < 3) begin
            failures++; $display("FAIL starve_resume_count got=%0d exp>=3", gq.size());
        end else if ({gq[0], gq[1], gq[2]} !== {32'h40, 32'h100, 32'h40}) begin
            failures++; $display("FAIL starve_resume_order got=%h %h %h exp=40 100 40", gq[0], gq[1], gq[2]);
        end
    endtask

    task automatic test_cancel();
        do_reset();
        inst_req = 1; inst_addr = 32'h80;
        next_cycle();
        next_cycle();
        inst_cancel = 1;
        data_req = 1; data_we = 1; data_be = 4'hF; data_addr = 32'h200; data_wdata = 32'hCAFE;
        next_cycle();
        inst_cancel = 0; inst_req = 0;
        @(negedge clk);
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin failures++; $display("FAIL cancel_drain_hold got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h80}); end
        next_cycle();
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        checks++; if ({inst_valid, mem_req} !== 2'b00) begin failures++; $display("FAIL cancel_discard got=%b exp=00", {inst_valid, mem_req}); end
        checks++; if (inst_rdata !== 32'h0) begin failures++; $display("FAIL cancel_rdata got=%h exp=0", inst_rdata); end
        next_cycle();
        mem_ack = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        checks++; if ({mem_req, mem_we, mem_addr, inst_valid} !== {1'b1, 1'b1, 32'h200, 1'b0}) begin failures++; $display("FAIL cancel_next_grant got=%h exp=%h", {mem_req, mem_we, mem_addr, inst_valid}, {1'b1, 1'b1, 32'h200, 1'b0}); end
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        checks++; if ({data_valid, data_rdata} !== {1'b1, 32'h12345678}) begin failures++; $display("FAIL cancel_data_resp got=%h exp=%h", {data_valid, data_rdata}, {1'b1, 32'h12345678}); end
        next_cycle();
        data_req = 0;
    endtask

    task automatic test_timeout();
        data_req = 1; data_we = 1; data_be = 4'hF; data_addr = 32'h300; data_wdata = 32'h1; mem_ack = 0;
        @(negedge clk);
        checks++; if (data_rdata !== 32'h12345678) begin failures++; $display("FAIL rdata_hold got=%h exp=12345678", data_rdata); end
        for (int c = 1; c <= TO; c++) begin
            next_cycle();
            @(negedge clk);
            checks++; if ({mem_req, bus_err, data_valid} !== 3'b100) begin failures++; $display("FAIL timeout_wait c%0d got=%b exp=100", c, {mem_req, bus_err, data_valid}); end
        end
        next_cycle();
        @(negedge clk);
        checks++; if ({mem_req, bus_err, data_valid} !== 3'b011) begin failures++; $display("FAIL timeout_expire got=%b exp=011", {mem_req, bus_err, data_valid}); end
        checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL timeout_rdata got=%h exp=0", data_rdata); end
        next_cycle();
        data_req = 0;
        @(negedge clk);
        checks++; if ({mem_req, bus_err, data_valid} !== 3'b000) begin failures++; $display("FAIL timeout_after got=%b exp=000", {mem_req, bus_err, data_valid}); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        data_req = 1; data_we = 0; data_be = 4'hF; data_addr = 32'h400;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", mem_req); end
        rst_n = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midop_async_drop got=%b exp=0", mem_req); end
        data_req = 0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            mem_ack = 1; mem_rdata = 32'hFFFF0000;
            @(negedge clk);
            checks++; if ({mem_req, data_valid, bus_err} !== 3'b000) begin failures++; $display("FAIL midop_after c%0d got=%b exp=000", c, {mem_req, data_valid, bus_err}); end
        end
        mem_ack = 0;
    endtask

    task automatic test_random();
        bit i_free, d_free;
        int lat;
        do_reset();
        i_free = 1; d_free = 1; lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cycle();
            if (i_free) begin
                inst_req = ($urandom_range(0, 9) < 6);
                inst_addr = $urandom;
            end
            inst_cancel = ($urandom_range(0, 19) == 0);
            if (d_free) begin
                data_req = ($urandom_range(0, 9) < 5);
                data_we = 1'($urandom);
                data_be = 4'($urandom);
                data_addr = $urandom;
                data_wdata = $urandom;
            end
            if (m_req && m_wait == 0) lat = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 3));
            mem_ack = m_req ? (m_wait == lat) : ($urandom_range(0, 15) == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            checks++; if (mem_req !== m_req) begin failures++; $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, m_req); end
            checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== {m_we, m_be, m_addr, m_wdata}) begin failures++; $display("FAIL rnd_mem_bus cyc=%0d got=%h exp=%h", cyc, {mem_we, mem_be, mem_addr, mem_wdata}, {m_we, m_be, m_addr, m_wdata}); end
            checks++; if ({inst_valid, inst_rdata} !== {m_iv, m_ir}) begin failures++; $display("FAIL rnd_inst_resp cyc=%0d got=%h exp=%h", cyc, {inst_valid, inst_rdata}, {m_iv, m_ir}); end
            checks++; if ({data_valid, data_rdata} !== {m_dv, m_dr}) begin failures++; $display("FAIL rnd_data_resp cyc=%0d got=%h exp=%h", cyc, {data_valid, data_rdata}, {m_dv, m_dr}); end
            checks++; if (bus_err !== m_err) begin failures++; $display("FAIL rnd_bus_err cyc=%0d got=%b exp=%b", cyc, bus_err, m_err); end
            checks++; if ({inst_done, data_done} !== {!inst_req || m_iv, !data_req || m_dv}) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, {inst_done, data_done}, {!inst_req || m_iv, !data_req || m_dv}); end
            i_free = !inst_req || m_iv || inst_cancel;
            d_free = !data_req || m_dv;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 0;
        inst_req = 0; inst_addr = '0; inst_cancel = 0;
        data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        model_reset();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_cancel();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
